tlp_mux: RTL and testbench
==========================

Name: tlp_mux

Overview:
- Transmit-side counterpart of the request demultiplexer: merges a memory-read TLP stream (r_in_*) and a memory-write TLP stream (w_in_*) into one outgoing TLP stream (out_*) toward the link layer.
- Arbitration is round-robin and packet-atomic: once a packet's SOP beat is accepted, its port holds the output until its EOP beat is accepted.
- The output is registered through a 2-entry skid buffer, so no combinational path exists from out_ready to r_in_ready or w_in_ready.

Parameters:
- DOUBLE_WORD, 32, double-word width in bits.
- HEADER_SIZE, 4*DOUBLE_WORD, TLP header width (4DW header).
- TLP_DATA_WIDTH, 8*DOUBLE_WORD, payload beat width.

Ports:
- clk  in  1  clock; single clock domain.
- rst  in  1  asynchronous, active-high reset.
- r_in_data  in  TLP_DATA_WIDTH  read-request beat data.
- r_in_hdr  in  HEADER_SIZE  read-request header, held for the whole packet.
- r_in_sop / r_in_eop  in  1 each  read-request packet delimiters.
- r_in_valid  in  1  read-request beat valid.
- r_in_ready  out  1  read port accepts a beat.
- w_in_data, w_in_hdr, w_in_sop, w_in_eop, w_in_valid  in  as the r_in_* ports  write-request stream.
- w_in_ready  out  1  write port accepts a beat.
- out_data, out_hdr, out_sop, out_eop  out  as the inputs  merged stream.
- out_valid  out  1  merged beat valid.
- out_ready  in  1  downstream accepts a beat.
- enable  in  1  when 0, no new packet is granted.
- err_orphan  out  1  one-cycle pulse: a non-SOP beat was discarded in IDLE.
- err_sop_in_pkt  out  1  one-cycle pulse: SOP seen from the granted port while in LOCK.

Behaviour:
- Reset: async assert. out_valid=0, out_sop=0, out_eop=0, out_data=0, out_hdr=0, r_in_ready=0, w_in_ready=0, err_*=0, skid buffer empty, FSM=IDLE, priority = read port first.
- A beat transfers on a port when valid & ready are both 1 in the same cycle.
- stage_ready = skid buffer not full. It is registered; it depends only on the buffer occupancy at the previous edge.
- FSM IDLE:
  - Candidate port p has p_valid & p_sop & enable.
  - If both ports are candidates, the round-robin pointer picks the port not granted last.
  - Winner: ready = stage_ready; the loser's ready = 0.
  - A port with valid & !sop (orphan) gets ready=1 (only when enable=1); the beat is discarded and err_orphan pulses. Orphan drain does not block the winner.
  - On the winner's SOP transfer: if eop=1 too (single-beat packet), stay IDLE and move the pointer to the other port. Otherwise go to LOCK(winner).
- FSM LOCK(g):
  - Only port g has ready = stage_ready; the other port's ready = 0 (no orphan drain).
  - enable is ignored.
  - If g sends sop=1: err_sop_in_pkt pulses and the beat is forwarded unchanged.
  - On g's EOP transfer: go to IDLE and move the pointer to the other port.
- Back-to-back packets: a new SOP may transfer in the cycle after the previous EOP, so there are zero bubbles when out_ready=1.
- Latency: an accepted input beat appears on out_* in the next cycle when the buffer is empty. Order is strictly preserved.
- Skid buffer:
  - 2 entries; out_* are driven from the head entry.
  - Head pops when out_valid & out_ready. Push and pop in the same cycle are allowed.
  - Full means 2 entries, which forces stage_ready=0 in the next cycle.
  - Sustained throughput is 1 beat/cycle while out_ready=1.
- Beat fields data/hdr/sop/eop are copied as-is; the block never modifies headers.
- Reset during a packet: the packet is dropped; the pointer and FSM return to their reset values.

Test Plan:
- Single-beat read (hdr[127:120]=8'h20, sop=eop=1), out_ready=1 -> out_valid=1 one cycle later with identical hdr/data; r_in_ready=1 in the transfer cycle; FSM stays IDLE.
- Both ports present a 3-beat packet at the same time after reset -> read packet first (3 consecutive beats), write packet follows with no gap; w_in_ready=0 throughout the read packet.
- Continuous 1-beat packets on both ports, out_ready=1 for 20 cycles -> strict R,W,R,W alternation; 20 beats out, no bubbles.
- out_ready=0 for 5 cycles mid-packet -> at most 2 beats buffered; ins_ready=0 from the cycle after the buffer is full; no beat lost or duplicated; order preserved after release.
- Orphan write beat (valid=1, sop=0) in IDLE with enable=1 -> w_in_ready=1, beat absent from output, err_orphan=1 for 1 cycle. With enable=0 and a valid read SOP -> no grant and r_in_ready=0; the packet proceeds once enable=1.
- Reset asserted in the middle of a 4-beat write -> out_valid=0 and both readies 0 immediately; after release a new read SOP is granted first.

Source files
------------

// File: rtl/tlp_mux.sv
`default_nettype none
// ============================================================================
// Module   : tlp_mux
// Purpose  : Merges a memory-read TLP stream (r_in_*) and a memory-write TLP
//            stream (w_in_*) into one outgoing TLP stream (out_*) toward the
//            link layer. Arbitration is round-robin and packet-atomic: once a
//            port's SOP beat is accepted, that port owns the output until its
//            EOP beat is accepted. The output is registered through a
//            2-entry skid buffer, so out_ready never reaches r_in_ready or
//            w_in_ready combinationally.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk             in   clock (single domain)
//   rst             in   asynchronous active-high reset
//   r_in_data/hdr   in   read-request beat data / header (header held per pkt)
//   r_in_sop/eop    in   read-request packet delimiters
//   r_in_valid      in   read-request beat valid
//   r_in_ready      out  read port accepts a beat
//   w_in_*          in   write-request stream, same shape as r_in_*
//   w_in_ready      out  write port accepts a beat
//   out_data/hdr    out  merged beat data / header
//   out_sop/eop     out  merged packet delimiters
//   out_valid       out  merged beat valid
//   out_ready       in   downstream accepts a beat
//   enable          in   0 = no new packet is granted
//   err_orphan      out  1-cycle pulse: non-SOP beat discarded while idle
//   err_sop_in_pkt  out  1-cycle pulse: SOP seen from the owning port mid-packet
// ============================================================================
module tlp_mux #(
  parameter int DOUBLE_WORD    = 32,
  parameter int HEADER_SIZE    = 4 * DOUBLE_WORD,
  parameter int TLP_DATA_WIDTH = 8 * DOUBLE_WORD
) (
  input  logic                      clk,
  input  logic                      rst,

  input  logic [TLP_DATA_WIDTH-1:0] r_in_data,
  input  logic [HEADER_SIZE-1:0]    r_in_hdr,
  input  logic                      r_in_sop,
  input  logic                      r_in_eop,
  input  logic                      r_in_valid,
  output logic                      r_in_ready,

  input  logic [TLP_DATA_WIDTH-1:0] w_in_data,
  input  logic [HEADER_SIZE-1:0]    w_in_hdr,
  input  logic                      w_in_sop,
  input  logic                      w_in_eop,
  input  logic                      w_in_valid,
  output logic                      w_in_ready,

  output logic [TLP_DATA_WIDTH-1:0] out_data,
  output logic [HEADER_SIZE-1:0]    out_hdr,
  output logic                      out_sop,
  output logic                      out_eop,
  output logic                      out_valid,
  input  logic                      out_ready,

  input  logic                      enable,
  output logic                      err_orphan,
  output logic                      err_sop_in_pkt
);

  // One buffered beat: {data, hdr, sop, eop}
  localparam int ENTRY_W = TLP_DATA_WIDTH + HEADER_SIZE + 2;

  // Round-robin pointer encoding: which port wins a simultaneous request.
  localparam logic PRIO_READ  = 1'b0;
  localparam logic PRIO_WRITE = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOCK_R = 2'd1,
    ST_LOCK_W = 2'd2
  } state_t;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  state_t               state_q, state_d;
  logic                 prio_q, prio_d;
  logic                 stage_ready_q;
  logic                 run_q;
  logic                 err_orphan_q, err_orphan_d;
  logic                 err_sop_q, err_sop_d;

  logic [ENTRY_W-1:0]   ent0_q, ent0_d;   // head entry, drives out_*
  logic [ENTRY_W-1:0]   ent1_q, ent1_d;
  logic [1:0]           cnt_q, cnt_d;

  // --------------------------------------------------------------------------
  // Arbitration / grant FSM
  // --------------------------------------------------------------------------
  logic r_cand, w_cand;
  logic win_r, win_w;
  logic r_orphan, w_orphan;
  logic r_rdy, w_rdy;
  logic fwd_r, fwd_w;

  assign r_cand = r_in_valid & r_in_sop & enable;
  assign w_cand = w_in_valid & w_in_sop & enable;

  // On a tie the pointer decides; a lone candidate always wins.
  assign win_r = r_cand & (~w_cand | (prio_q == PRIO_READ));
  assign win_w = w_cand & (~r_cand | (prio_q == PRIO_WRITE));

  // Orphan beats are drained without touching the buffer, so they do not
  // depend on stage_ready. run_q keeps the drain off during/just out of reset.
  assign r_orphan = r_in_valid & ~r_in_sop & enable & run_q;
  assign w_orphan = w_in_valid & ~w_in_sop & enable & run_q;

  always_comb begin
    state_d      = state_q;
    prio_d       = prio_q;
    r_rdy        = 1'b0;
    w_rdy        = 1'b0;
    fwd_r        = 1'b0;
    fwd_w        = 1'b0;
    err_orphan_d = 1'b0;
    err_sop_d    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (win_r)         r_rdy = stage_ready_q;
        else if (r_orphan) r_rdy = 1'b1;

        if (win_w)         w_rdy = stage_ready_q;
        else if (w_orphan) w_rdy = 1'b1;

        fwd_r = win_r & stage_ready_q;
        fwd_w = win_w & stage_ready_q;

        err_orphan_d = (r_orphan & ~win_r) | (w_orphan & ~win_w);

        if (fwd_r) begin
          // Single-beat packet releases the output immediately.
          if (r_in_eop) prio_d  = PRIO_WRITE;
          else          state_d = ST_LOCK_R;
        end else if (fwd_w) begin
          if (w_in_eop) prio_d  = PRIO_READ;
          else          state_d = ST_LOCK_W;
        end
      end

      ST_LOCK_R: begin
        r_rdy = stage_ready_q;
        fwd_r = r_in_valid & stage_ready_q;
        if (fwd_r) begin
          err_sop_d = r_in_sop;
          if (r_in_eop) begin
            state_d = ST_IDLE;
            prio_d  = PRIO_WRITE;
          end
        end
      end

      ST_LOCK_W: begin
        w_rdy = stage_ready_q;
        fwd_w = w_in_valid & stage_ready_q;
        if (fwd_w) begin
          err_sop_d = w_in_sop;
          if (w_in_eop) begin
            state_d = ST_IDLE;
            prio_d  = PRIO_READ;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign r_in_ready = r_rdy;
  assign w_in_ready = w_rdy;

  // --------------------------------------------------------------------------
  // 2-entry skid buffer
  // --------------------------------------------------------------------------
  logic               push, pop;
  logic [ENTRY_W-1:0] push_entry;

  assign push       = fwd_r | fwd_w;
  assign push_entry = fwd_w ? {w_in_data, w_in_hdr, w_in_sop, w_in_eop}
                            : {r_in_data, r_in_hdr, r_in_sop, r_in_eop};
  assign pop        = (cnt_q != 2'd0) & out_ready;

  always_comb begin
    ent0_d = ent0_q;
    ent1_d = ent1_q;
    cnt_d  = cnt_q;

    case ({push, pop})
      2'b10: begin
        // Pushes never arrive when full: stage_ready was already low.
        if (cnt_q == 2'd0) begin
          ent0_d = push_entry;
          cnt_d  = 2'd1;
        end else if (cnt_q == 2'd1) begin
          ent1_d = push_entry;
          cnt_d  = 2'd2;
        end
      end
      2'b01: begin
        ent0_d = ent1_q;
        cnt_d  = cnt_q - 2'd1;
      end
      2'b11: begin
        if (cnt_q == 2'd1) begin
          ent0_d = push_entry;
        end else begin
          ent0_d = ent1_q;
          ent1_d = push_entry;
        end
      end
      default: begin
      end
    endcase
  end

  assign out_valid = (cnt_q != 2'd0);
  assign {out_data, out_hdr, out_sop, out_eop} = ent0_q;

  assign err_orphan     = err_orphan_q;
  assign err_sop_in_pkt = err_sop_q;

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      prio_q        <= PRIO_READ;
      stage_ready_q <= 1'b0;
      run_q         <= 1'b0;
      err_orphan_q  <= 1'b0;
      err_sop_q     <= 1'b0;
      ent0_q        <= '0;
      ent1_q        <= '0;
      cnt_q         <= 2'd0;
    end else begin
      state_q       <= state_d;
      prio_q        <= prio_d;
      // Registered from next occupancy: low exactly while the buffer holds 2.
      stage_ready_q <= (cnt_d != 2'd2);
      run_q         <= 1'b1;
      err_orphan_q  <= err_orphan_d;
      err_sop_q     <= err_sop_d;
      ent0_q        <= ent0_d;
      ent1_q        <= ent1_d;
      cnt_q         <= cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_tlp_mux.sv
`default_nettype none
// ============================================================================
// Module   : tb_tlp_mux
// Purpose  : Self-checking bench for tlp_mux: a cycle-by-cycle vector table
//            plus directed sequences for alternation, back-pressure and reset.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tlp_mux;

  localparam int DWW = 32;
  localparam int HS  = 4 * DWW;
  localparam int TDW = 8 * DWW;

  logic           clk = 1'b0;
  logic           rst;
  logic [TDW-1:0] r_in_data, w_in_data, out_data;
  logic [HS-1:0]  r_in_hdr, w_in_hdr, out_hdr;
  logic           r_in_sop, r_in_eop, r_in_valid, r_in_ready;
  logic           w_in_sop, w_in_eop, w_in_valid, w_in_ready;
  logic           out_sop, out_eop, out_valid, out_ready;
  logic           enable, err_orphan, err_sop_in_pkt;

  always #5 clk = ~clk;

  tlp_mux #(.DOUBLE_WORD(DWW)) dut (
    .clk            (clk),
    .rst            (rst),
    .r_in_data      (r_in_data),
    .r_in_hdr       (r_in_hdr),
    .r_in_sop       (r_in_sop),
    .r_in_eop       (r_in_eop),
    .r_in_valid     (r_in_valid),
    .r_in_ready     (r_in_ready),
    .w_in_data      (w_in_data),
    .w_in_hdr       (w_in_hdr),
    .w_in_sop       (w_in_sop),
    .w_in_eop       (w_in_eop),
    .w_in_valid     (w_in_valid),
    .w_in_ready     (w_in_ready),
    .out_data       (out_data),
    .out_hdr        (out_hdr),
    .out_sop        (out_sop),
    .out_eop        (out_eop),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .enable         (enable),
    .err_orphan     (err_orphan),
    .err_sop_in_pkt (err_sop_in_pkt)
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic       rv, rs, re;
    logic [7:0] rt;
    logic       wv, ws, we;
    logic [7:0] wt;
    logic       ordy, en;
    logic       xrr, xwr, xov, xos, xoe;
    logic [7:0] xot;
    logic       xeo, xes;
  } vec_t;

  function automatic logic [TDW-1:0] dat(input logic [7:0] t);
    return {32{t}};
  endfunction

  function automatic logic [HS-1:0] hdr(input logic [7:0] t);
    return {t, 112'h0, ~t};
  endfunction

  function automatic vec_t mk(
    input logic rv, rs, re, input logic [7:0] rt,
    input logic wv, ws, we, input logic [7:0] wt,
    input logic ordy, en,
    input logic xrr, xwr, xov, xos, xoe, input logic [7:0] xot,
    input logic xeo, xes);
    vec_t v;
    v.rv = rv; v.rs = rs; v.re = re; v.rt = rt;
    v.wv = wv; v.ws = ws; v.we = we; v.wt = wt;
    v.ordy = ordy; v.en = en;
    v.xrr = xrr; v.xwr = xwr; v.xov = xov; v.xos = xos; v.xoe = xoe; v.xot = xot;
    v.xeo = xeo; v.xes = xes;
    return v;
  endfunction

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic rv, rs, re, input logic [7:0] rt,
                       input logic wv, ws, we, input logic [7:0] wt,
                       input logic ordy, en);
    r_in_valid = rv; r_in_sop = rs; r_in_eop = re;
    r_in_data  = dat(rt); r_in_hdr = hdr(rt);
    w_in_valid = wv; w_in_sop = ws; w_in_eop = we;
    w_in_data  = dat(wt); w_in_hdr = hdr(wt);
    out_ready  = ordy;
    enable     = en;
  endtask

  task automatic chk_out(input string name, input logic xov, xos, xoe, input logic [7:0] xot);
    chk({name, " out_valid"}, 256'(out_valid), 256'(xov));
    if (xov) begin
      chk({name, " out_data"}, out_data, dat(xot));
      chk({name, " out_hdr"},  256'(out_hdr), 256'(hdr(xot)));
      chk({name, " out_sop"},  256'(out_sop), 256'(xos));
      chk({name, " out_eop"},  256'(out_eop), 256'(xoe));
    end
  endtask

  vec_t tbl [21];

  initial begin
    // ---------------- vector table (prio = read after reset) -------------
    //            r: v s e tag    w: v s e tag    ordy en  exp: rr wr ov os oe tag   eo es
    // both ports offer a 3-beat packet: read first, write follows with no gap
    tbl[0]  = mk(1,1,0,8'h11, 1,1,0,8'h21, 1,1, 1,0,0,0,0,8'h00, 0,0);
    tbl[1]  = mk(1,0,0,8'h12, 1,1,0,8'h21, 1,1, 1,0,1,1,0,8'h11, 0,0);
    tbl[2]  = mk(1,0,1,8'h13, 1,1,0,8'h21, 1,1, 1,0,1,0,0,8'h12, 0,0);
    tbl[3]  = mk(0,0,0,8'h00, 1,1,0,8'h21, 1,1, 0,1,1,0,1,8'h13, 0,0);
    tbl[4]  = mk(0,0,0,8'h00, 1,0,0,8'h22, 1,1, 0,1,1,1,0,8'h21, 0,0);
    tbl[5]  = mk(0,0,0,8'h00, 1,0,1,8'h23, 1,1, 0,1,1,0,0,8'h22, 0,0);
    tbl[6]  = mk(0,0,0,8'h00, 0,0,0,8'h00, 1,1, 0,0,1,0,1,8'h23, 0,0);
    tbl[7]  = mk(0,0,0,8'h00, 0,0,0,8'h00, 1,1, 0,0,0,0,0,8'h00, 0,0);
    // single-beat read, one-cycle latency
    tbl[8]  = mk(1,1,1,8'h20, 0,0,0,8'h00, 1,1, 1,0,0,0,0,8'h00, 0,0);
    tbl[9]  = mk(0,0,0,8'h00, 0,0,0,8'h00, 1,1, 0,0,1,1,1,8'h20, 0,0);
    // orphan write beat: drained, not forwarded, err_orphan next cycle
    tbl[10] = mk(0,0,0,8'h00, 1,0,0,8'h99, 1,1, 0,1,0,0,0,8'h00, 0,0);
    tbl[11] = mk(0,0,0,8'h00, 0,0,0,8'h00, 1,1, 0,0,0,0,0,8'h00, 1,0);
    // enable=0 blocks a read SOP until enable returns
    tbl[12] = mk(1,1,1,8'h30, 0,0,0,8'h00, 1,0, 0,0,0,0,0,8'h00, 0,0);
    tbl[13] = mk(1,1,1,8'h30, 0,0,0,8'h00, 1,0, 0,0,0,0,0,8'h00, 0,0);
    tbl[14] = mk(1,1,1,8'h30, 0,0,0,8'h00, 1,1, 1,0,0,0,0,8'h00, 0,0);
    tbl[15] = mk(0,0,0,8'h00, 0,0,0,8'h00, 1,1, 0,0,1,1,1,8'h30, 0,0);
    // SOP inside a locked write packet: forwarded, err_sop_in_pkt pulses;
    // enable=0 in row 18 is ignored while locked
    tbl[16] = mk(0,0,0,8'h00, 1,1,0,8'h40, 1,1, 0,1,0,0,0,8'h00, 0,0);
    tbl[17] = mk(0,0,0,8'h00, 1,1,0,8'h41, 1,1, 0,1,1,1,0,8'h40, 0,0);
    tbl[18] = mk(0,0,0,8'h00, 1,0,1,8'h42, 1,0, 0,1,1,1,0,8'h41, 0,1);
    tbl[19] = mk(0,0,0,8'h00, 0,0,0,8'h00, 1,1, 0,0,1,0,1,8'h42, 0,0);
    tbl[20] = mk(0,0,0,8'h00, 0,0,0,8'h00, 1,1, 0,0,0,0,0,8'h00, 0,0);

    // ---------------- reset state ----------------------------------------
    rst = 1'b1;
    drive(1,1,1,8'h55, 1,1,1,8'h66, 1,1);
    repeat (2) @(negedge clk);
    #1;
    chk("reset out_valid",  256'(out_valid), 256'(0));
    chk("reset out_sop",    256'(out_sop), 256'(0));
    chk("reset out_eop",    256'(out_eop), 256'(0));
    chk("reset out_data",   out_data, 256'(0));
    chk("reset out_hdr",    256'(out_hdr), 256'(0));
    chk("reset r_in_ready", 256'(r_in_ready), 256'(0));
    chk("reset w_in_ready", 256'(w_in_ready), 256'(0));
    chk("reset err_orphan", 256'(err_orphan), 256'(0));
    chk("reset err_sop",    256'(err_sop_in_pkt), 256'(0));
    @(negedge clk);
    drive(0,0,0,8'h00, 0,0,0,8'h00, 1,1);
    rst = 1'b0;

    // ---------------- table ----------------------------------------------
    for (int i = 0; i < 21; i++) begin
      @(negedge clk);
      drive(tbl[i].rv, tbl[i].rs, tbl[i].re, tbl[i].rt,
            tbl[i].wv, tbl[i].ws, tbl[i].we, tbl[i].wt, tbl[i].ordy, tbl[i].en);
      #1;
      chk($sformatf("row%0d r_in_ready", i), 256'(r_in_ready), 256'(tbl[i].xrr));
      chk($sformatf("row%0d w_in_ready", i), 256'(w_in_ready), 256'(tbl[i].xwr));
      chk_out($sformatf("row%0d", i), tbl[i].xov, tbl[i].xos, tbl[i].xoe, tbl[i].xot);
      chk($sformatf("row%0d err_orphan", i), 256'(err_orphan), 256'(tbl[i].xeo));
      chk($sformatf("row%0d err_sop", i), 256'(err_sop_in_pkt), 256'(tbl[i].xes));
    end

    // ---------------- continuous 1-beat packets: R,W,R,W ... -------------
    for (int i = 0; i < 22; i++) begin
      logic [7:0] ti;
      logic [7:0] tp;
      ti = 8'(i);
      tp = 8'(i - 1);
      @(negedge clk);
      if (i < 20) drive(1,1,1,8'h80 | ti, 1,1,1,ti, 1,1);
      else        drive(0,0,0,8'h00, 0,0,0,8'h00, 1,1);
      #1;
      if (i < 20) begin
        chk($sformatf("alt%0d r_in_ready", i), 256'(r_in_ready), 256'(i % 2 == 0));
        chk($sformatf("alt%0d w_in_ready", i), 256'(w_in_ready), 256'(i % 2 == 1));
      end
      if (i == 0 || i == 21)
        chk_out($sformatf("alt%0d", i), 1'b0, 1'b0, 1'b0, 8'h00);
      else
        chk_out($sformatf("alt%0d", i), 1'b1, 1'b1, 1'b1,
                ((i - 1) % 2 == 0) ? (8'h80 | tp) : tp);
    end

    // ---------------- back-pressure: out_ready low 5 cycles mid-packet --
    begin
      logic       s_ordy [13] = '{1,0,0,0,0,0,1,1,1,1,1,1,1};
      logic       s_rr   [13] = '{1,1,0,0,0,0,0,1,1,1,1,0,0};
      logic       s_ov   [13] = '{0,1,1,1,1,1,1,1,1,1,1,1,0};
      logic [7:0] s_tag  [13] = '{8'h00,8'h60,8'h60,8'h60,8'h60,8'h60,8'h60,
                                  8'h61,8'h62,8'h63,8'h64,8'h65,8'h00};
      int b;
      b = 0;
      for (int c = 0; c < 13; c++) begin
        @(negedge clk);
        drive(b < 6, b == 0, b == 5, 8'h60 + 8'(b), 0,0,0,8'h00, s_ordy[c], 1);
        #1;
        chk($sformatf("stall%0d r_in_ready", c), 256'(r_in_ready), 256'(s_rr[c]));
        chk_out($sformatf("stall%0d", c), s_ov[c], s_tag[c] == 8'h60, s_tag[c] == 8'h65, s_tag[c]);
        if (r_in_valid && r_in_ready) b++;
      end
      chk("stall beats accepted", 256'(b), 256'(6));
    end

    // ---------------- reset in the middle of a 4-beat write --------------
    @(negedge clk);
    drive(0,0,0,8'h00, 1,1,0,8'h70, 1,1);
    #1;
    chk("rstpkt0 w_in_ready", 256'(w_in_ready), 256'(1));
    @(negedge clk);
    drive(0,0,0,8'h00, 1,0,0,8'h71, 1,1);
    #1;
    chk_out("rstpkt1", 1'b1, 1'b1, 1'b0, 8'h70);
    @(negedge clk);
    drive(1,1,1,8'h77, 1,0,0,8'h72, 1,1);
    #1;
    rst = 1'b1;
    #1;
    chk("rstpkt out_valid",  256'(out_valid), 256'(0));
    chk("rstpkt r_in_ready", 256'(r_in_ready), 256'(0));
    chk("rstpkt w_in_ready", 256'(w_in_ready), 256'(0));
    chk("rstpkt out_data",   out_data, 256'(0));
    @(negedge clk);
    rst = 1'b0;
    drive(1,1,1,8'h77, 1,1,0,8'h78, 1,1);
    @(negedge clk);
    #1;
    // pointer back at read-first: read wins the tie
    chk("postrst r_in_ready", 256'(r_in_ready), 256'(1));
    chk("postrst w_in_ready", 256'(w_in_ready), 256'(0));
    chk_out("postrst0", 1'b0, 1'b0, 1'b0, 8'h00);
    @(negedge clk);
    drive(0,0,0,8'h00, 0,0,0,8'h00, 1,1);
    #1;
    chk_out("postrst1", 1'b1, 1'b1, 1'b1, 8'h77);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
